// File: rtl/conv_engine_stream.sv
// Streaming KxK 2D convolution over multi-channel 8-bit pixels with internal line
// buffers, a sliding window, a two-stage MAC/saturate pipeline and ready/valid on both sides.
module conv_engine_stream #(
  parameter int K          = 5,
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int CHANNELS   = 3,
  parameter int SHIFT      = 0
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        coef_we,
  input  logic [$clog2(K*K)-1:0]      coef_addr,
  input  logic signed [7:0]           coef_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [8*CHANNELS-1:0]       s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [8*CHANNELS-1:0]       m_data,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int NTAP  = K * K;
  localparam int CA_W  = $clog2(NTAP);
  localparam int ACC_W = 17 + $clog2(NTAP);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int PW    = 8 * CHANNELS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                   state_r;
  logic [ROW_W-1:0]         row_r;
  logic [COL_W-1:0]         col_r;
  logic signed [7:0]        coef_r [NTAP];
  logic [PW-1:0]            lb_r   [K-1][IMG_WIDTH];
  logic [PW-1:0]            win_r  [K][K];
  logic                     p0_v_r;
  logic                     p1_v_r;
  logic signed [ACC_W-1:0]  sum_r  [CHANNELS];
  logic signed [ACC_W-1:0]  sum_s  [CHANNELS];
  logic [PW-1:0]            sat_s;
  logic                     m_valid_r;
  logic [PW-1:0]            m_data_r;
  logic                     frame_done_r;
  logic                     adv_s;
  logic                     acc_s;
  logic                     s_ready_s;

  function automatic logic signed [ACC_W-1:0] mac(input logic [7:0] px, input logic signed [7:0] cf);
    logic signed [8:0]  p9;
    logic signed [16:0] pr;
    p9 = $signed({1'b0, px});
    pr = 17'(p9) * 17'(cf);
    return ACC_W'(pr);
  endfunction

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh[ACC_W-1]) begin
      return 8'd0;
    end else if (|sh[ACC_W-2:8]) begin
      return 8'hFF;
    end else begin
      return sh[7:0];
    end
  endfunction

  assign adv_s      = !m_valid_r || m_ready;
  assign s_ready_s  = (state_r == RUN) && adv_s;
  assign acc_s      = s_valid && s_ready_s;
  assign s_ready    = s_ready_s;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_r;

  // Line buffers and window: lb_r[0] is the previous row, lb_r[K-2] the oldest; window column K-1 is newest.
  always_ff @(posedge CLK) begin
    if (acc_s) begin
      lb_r[0][col_r] <= s_data;
      for (int j = 1; j < K - 1; j++) lb_r[j][col_r] <= lb_r[j-1][col_r];
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K - 1; j++) win_r[i][j] <= win_r[i][j+1];
      for (int i = 0; i < K - 1; i++) win_r[i][K-1] <= lb_r[K-2-i][col_r];
      win_r[K-1][K-1] <= s_data;
    end
  end

  // Per-channel MAC over the window, coefficients row-major from the top-left tap.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s[c] = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          sum_s[c] = sum_s[c] + mac(win_r[i][j][8*c +: 8], coef_r[i*K+j]);
    end
  end

  // Shift and clamp each registered sum into its output byte.
  always_comb begin
    sat_s = '0;
    for (int c = 0; c < CHANNELS; c++) sat_s[8*c +: 8] = sat8(sum_r[c]);
  end

  // Frame control, coefficient bank and the two pipeline stages.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r      <= IDLE;
      row_r        <= '0;
      col_r        <= '0;
      p0_v_r       <= 1'b0;
      p1_v_r       <= 1'b0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
      frame_done_r <= 1'b0;
      for (int t = 0; t < NTAP; t++) coef_r[t] <= 8'sd0;
      for (int c = 0; c < CHANNELS; c++) sum_r[c] <= '0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (coef_we && (coef_addr < CA_W'(NTAP))) coef_r[coef_addr] <= coef_data;
          if (start) begin
            state_r <= RUN;
            row_r   <= '0;
            col_r   <= '0;
          end
        end
        RUN: begin
          if (acc_s) begin
            if (col_r == COL_W'(IMG_WIDTH - 1)) begin
              col_r <= '0;
              if (row_r == ROW_W'(IMG_HEIGHT - 1)) begin
                row_r   <= '0;
                state_r <= FLUSH;
              end else begin
                row_r <= row_r + ROW_W'(1);
              end
            end else begin
              col_r <= col_r + COL_W'(1);
            end
          end
        end
        FLUSH: begin
          if (!p0_v_r && !p1_v_r && !m_valid_r) begin
            state_r      <= IDLE;
            frame_done_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase

      // A window is complete only once K-1 full rows and K-1 columns precede the pixel.
      if (acc_s) begin
        p0_v_r <= (row_r >= ROW_W'(K - 1)) && (col_r >= COL_W'(K - 1));
      end else if (adv_s) begin
        p0_v_r <= 1'b0;
      end
      if (adv_s) begin
        p1_v_r    <= p0_v_r;
        sum_r     <= sum_s;
        m_valid_r <= p1_v_r;
        m_data_r  <= sat_s;
      end
    end
  end

endmodule

// File: doc/conv_engine_stream.md
Name: conv_engine_stream

Overview:
- Parametrised streaming KxK 2D convolution engine for multi-channel 8-bit pixels (default 3-channel, 24-bit RGB words).
- Contains its own line buffers, sliding window, per-channel MAC tree, shift/saturate stage and ready/valid handshakes on both sides.
- Sits between the DDR read stream and the DDR write shift register.
- Replaces the fixed 5x5/45-pixel engine with a frame-controlled, back-pressure-aware version.

Parameters:
- K, 5, kernel side length; odd, 3..7.
- IMG_WIDTH, 45, pixels per row; must be at least K.
- IMG_HEIGHT, 45, rows per frame; must be at least K.
- CHANNELS, 3, independent 8-bit channels per pixel word.
- SHIFT, 0, arithmetic right shift applied to each accumulator before saturation.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE; ignored otherwise.
- coef_we  in  1  coefficient write strobe; honoured only in IDLE.
- coef_addr  in  $clog2(K*K)  coefficient index, row-major (0 = top-left); addresses >= K*K are ignored.
- coef_data  in  8  signed coefficient; shared by all channels.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  engine accepts the pixel this cycle.
- s_data  in  8*CHANNELS  pixel word; channel c occupies bits [8c+7:8c]; unsigned.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts.
- m_data  out  8*CHANNELS  convolved pixel word, same channel packing as s_data.
- busy  out  1  high in RUN and FLUSH.
- frame_done  out  1  one-cycle pulse on the cycle of the FLUSH->IDLE transition.

Behaviour:
- Reset values:
  - Outputs: s_ready=0, m_valid=0, m_data=0, busy=0, frame_done=0.
  - State: state=IDLE; row/col counters=0; pipeline valid bits=0.
  - Coefficients reset to 0. Line-buffer contents are don't-care.
- A handshake occurs when valid && ready on the same edge. Accept condition: acc = s_valid && s_ready.
- Pipeline advance enable: adv = !m_valid || m_ready.
- s_ready = (state==RUN) && adv.
- FSM:
  - IDLE: coefficient writes take effect. start -> RUN; counters cleared.
  - RUN: each accepted pixel advances col; on col wrap, row advances.
    - Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> FLUSH.
  - FLUSH: s_ready=0. When both pipeline stages and m_valid are empty -> IDLE, with frame_done=1 for one cycle.
- Line buffers:
  - K-1 rows of IMG_WIDTH entries per channel.
  - The KxK window shifts by one column per accepted pixel only.
  - Nothing moves on a cycle without acceptance.
- Window validity:
  - The window for accepted pixel (r,c) is valid iff r >= K-1 and c >= K-1 (no padding).
  - It is centred at (r-(K-1)/2, c-(K-1)/2).
  - Each frame produces exactly (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1) outputs, in raster order.
  - Windows never straddle a row wrap.
- Arithmetic, per channel:
  - Each product is unsigned 8-bit pixel times signed 8-bit coefficient, giving a 17-bit signed product.
  - Products are summed at width 17+$clog2(K*K) signed, with no overflow possible.
  - The sum is arithmetically shifted right by SHIFT.
  - Saturation: result < 0 gives 0; result > 255 gives 255; otherwise the low 8 bits.
- Latency and pipeline:
  - Two stages: stage 1 registers the sums; stage 2 registers the saturated result into m_data/m_valid.
  - With m_ready held high, m_valid rises 2 cycles after the accepting edge of the pixel that completes a valid window.
  - Full throughput is 1 pixel per cycle.
- Backpressure:
  - While m_valid && !m_ready, m_data and m_valid hold stable and s_ready=0.
  - No pixel is lost or duplicated.
- Simultaneous events:
  - start and coef_we in the same IDLE cycle: both take effect; the write lands before the first pixel.
  - coef_we during RUN or FLUSH is dropped; coefficients stay constant for the whole frame.
  - start during RUN or FLUSH is ignored.
- Reset mid-frame: returns to IDLE on the next edge.
  - All pipeline valid bits and the partial frame are discarded; no frame_done.
  - Coefficients are cleared to 0.

Test Plan:
- Identity, all channels:
  - Stimulus: K=3, IMG_WIDTH=8, IMG_HEIGHT=6, SHIFT=0, coef[4]=1, others 0; pixel (r,c) channel ch = 10r+c+ch; m_ready=1.
  - Required: exactly 24 outputs; output n (row R = n div 6, col C = n mod 6) equals input (R+1, C+1).
  - Required: the first m_valid comes 2 cycles after accepting pixel (2,2); frame_done then pulses once.
- Box sum with saturation: all 9 coef=1, constant input 40 -> every output is 255 (360 clamped).
- Box average: all 9 coef=1, SHIFT=3, constant input 40 -> every output is 45 (360>>3).
- Negative clamp: coef[4]=-1, input 100 -> every output is 0.
- Backpressure:
  - Stimulus: same identity frame; m_ready toggles with a random 50% duty; s_valid gaps are random.
  - Required: the output sequence is bit-identical to the m_ready=1 run.
  - Required: m_data stays stable while m_valid && !m_ready; s_ready stays low during stalls.
- Coefficient locking and reset:
  - Stimulus: coef_we with coef_data=7 at coef_addr=4 during RUN.
  - Required: no effect on outputs; the readback frame after return to IDLE still shows identity.
  - Stimulus: assert reset after 20 accepted pixels.
  - Required: next cycle busy=0, m_valid=0, no frame_done; a fresh start runs a complete correct frame after coefficients are reloaded.
